// File: rtl/sine_dac_sequencer.sv
// sine_dac_sequencer
//   Sine-sample path sequencer. Each accepted sample tick does four things:
//   it advances a phase accumulator, waits for the sine ROM read to settle,
//   builds the frame {CMD, sample, 4'b0000}, and shifts the frame out
//   MSB-first to a serial DAC. The serial link uses a chip-select and a
//   divided serial clock.
//
// Ports
//   clk, rst_n   system clock; asynchronous active-low reset
//   tick         one-cycle sample request
//   enable       gates acceptance of new ticks (a running frame completes)
//   phase_step   phase increment, sampled when a tick is accepted
//   rom_addr     ROM read address (latched phase)
//   rom_data     ROM read data, valid ROM_LATENCY cycles after rom_addr
//   sclk         serial clock, idles low; the DAC samples SO on rising edges
//   cs_n         DAC chip-select, active low
//   SO           serial data out
//   busy         high from tick acceptance until the frame ends
//   overrun      sticky: a tick arrived while busy
//   clr_overrun  synchronous clear of overrun (a set in the same cycle wins)
module sine_dac_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned SCLK_DIV    = 2,
  parameter logic [3:0]  CMD         = 4'b0011
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] phase_step,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  SO,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned LAT_W   = 3;
  localparam int unsigned DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LATENCY - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SHIFT,
    ST_END
  } state_t;

  state_t                state_q,  state_d;
  logic [ADDR_WIDTH-1:0] phase_q,  phase_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [FRAME_W-1:0]    shreg_q,  shreg_d;
  logic [BIT_W-1:0]      bit_q,    bit_d;
  logic [DIV_W-1:0]      div_q,    div_d;
  logic [LAT_W-1:0]      lat_q,    lat_d;
  logic                  sclk_q,   sclk_d;
  logic                  cs_n_q,   cs_n_d;
  logic                  so_q,     so_d;
  logic                  busy_q,   busy_d;
  logic                  ovr_q,    ovr_d;

  logic [FRAME_W-1:0]    frame_c;

  // DAC command frame built from the current ROM sample
  assign frame_c = {CMD, rom_data, 4'b0000};

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      addr_q  <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      lat_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      so_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      lat_q   <= lat_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      so_q    <= so_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    addr_d  = addr_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    div_d   = div_q;
    lat_d   = lat_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    so_d    = so_q;
    busy_d  = busy_q;
    ovr_d   = ovr_q;

    // Any tick seen while busy (END included) is dropped and flagged
    if (tick && busy_q) begin
      ovr_d = 1'b1;
    end else if (clr_overrun) begin
      ovr_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // rom_addr keeps the pre-increment phase until the frame ends
        if (tick && enable) begin
          state_d = ST_FETCH;
          busy_d  = 1'b1;
          phase_d = phase_q + phase_step;
          lat_d   = '0;
        end
      end

      ST_FETCH: begin
        if (lat_q == LAT_LAST) begin
          state_d = ST_LOAD;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      ST_LOAD: begin
        shreg_d = frame_c;
        so_d    = frame_c[FRAME_W-1];
        cs_n_d  = 1'b0;
        sclk_d  = 1'b0;
        bit_d   = '0;
        div_d   = '0;
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        // Each sclk phase lasts SCLK_DIV clk cycles; low phase first
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            // Falling edge: present the next bit, or finish after bit 15
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              so_d    = 1'b0;
              state_d = ST_END;
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              so_d    = shreg_q[FRAME_W-2];
              shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_END: begin
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
        addr_d  = phase_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rom_addr = addr_q;
  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;
  assign SO       = so_q;
  assign busy     = busy_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_sine_dac_sequencer.sv
// tb_sine_dac_sequencer
//   Two instances: dut0 with the default parameters and dut1 with
//   ROM_LATENCY=3, SCLK_DIV=1, each fed by a ROM model that has the matching
//   read latency. The stimulus pushes one expected frame per tick that should
//   be accepted. The monitor rebuilds every frame from the sclk rising edges.
//   When busy falls, it pops the expected entry and compares the data, the bit
//   count, the busy length and the cs_n-low length.
module tb_sine_dac_sequencer;

  typedef struct {
    logic [15:0] frame;
    int          busy_len;
    int          cs_len;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       clr_overrun;
  logic       tick0, tick1;
  logic [7:0] step0, step1;
  logic [7:0] rom_addr0, rom_addr1;
  logic [7:0] rom_data0, rom_data1;
  logic       sclk0, cs_n0, so0, busy0, ovr0;
  logic       sclk1, cs_n1, so1, busy1, ovr1;
  logic [7:0] pipe1 [3];

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   checks = 0;
  int   errors = 0;

  logic        sclk_prev [2];
  logic        busy_prev [2];
  logic [15:0] bits      [2];
  int          nbits     [2];
  int          bcnt      [2];
  int          ccnt      [2];

  always #5 clk = ~clk;

  sine_dac_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick0), .enable(enable),
    .phase_step(step0), .rom_addr(rom_addr0), .rom_data(rom_data0),
    .sclk(sclk0), .cs_n(cs_n0), .SO(so0), .busy(busy0),
    .overrun(ovr0), .clr_overrun(clr_overrun)
  );

  sine_dac_sequencer #(.ROM_LATENCY(3), .SCLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick1), .enable(enable),
    .phase_step(step1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .sclk(sclk1), .cs_n(cs_n1), .SO(so1), .busy(busy1),
    .overrun(ovr1), .clr_overrun(clr_overrun)
  );

  // ROM contents: 0x00 -> A5, otherwise addr ^ 3C
  function automatic logic [7:0] rom_fn(input logic [7:0] a);
    return (a == 8'h00) ? 8'hA5 : (a ^ 8'h3C);
  endfunction

  always @(posedge clk) rom_data0 <= rom_fn(rom_addr0);

  always @(posedge clk) begin
    pipe1[0] <= rom_fn(rom_addr1);
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign rom_data1 = pipe1[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic mon_clear();
    for (int g = 0; g < 2; g++) begin
      sclk_prev[g] = 1'b0;
      busy_prev[g] = 1'b0;
      bits[g]      = '0;
      nbits[g]     = 0;
      bcnt[g]      = 0;
      ccnt[g]      = 0;
    end
  endtask

  task automatic mon_step(input int g, input logic sc, input logic cs, input logic so, input logic bz);
    exp_t e;
    logic have;
    have = 1'b0;
    check($sformatf("sclk_high_cs_idle%0d", g), 32'(sc & cs), 32'd0);
    if (bz) bcnt[g]++;
    if (!cs) ccnt[g]++;
    if (sc && !sclk_prev[g]) begin
      bits[g] = {bits[g][14:0], so};
      nbits[g]++;
    end
    if (!bz && busy_prev[g]) begin
      if (g == 0 && exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        have = 1'b1;
      end else if (g == 1 && exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        have = 1'b1;
      end
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame dut%0d actual=%0h required=none", g, bits[g]);
      end else begin
        check($sformatf("frame_data%0d", g), 32'(bits[g]), 32'(e.frame));
        check($sformatf("frame_bits%0d", g), 32'(nbits[g]), 32'd16);
        check($sformatf("busy_len%0d", g), 32'(bcnt[g]), 32'(e.busy_len));
        check($sformatf("cs_low_len%0d", g), 32'(ccnt[g]), 32'(e.cs_len));
      end
      bits[g]  = '0;
      nbits[g] = 0;
      bcnt[g]  = 0;
      ccnt[g]  = 0;
    end
    sclk_prev[g] = sc;
    busy_prev[g] = bz;
  endtask

  // Monitor: samples on the falling clk edge, away from register updates
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_clear();
    end else begin
      mon_step(0, sclk0, cs_n0, so0, busy0);
      mon_step(1, sclk1, cs_n1, so1, busy1);
    end
  end

  task automatic push_exp(input int g, input logic [15:0] frame);
    exp_t e;
    e.frame = frame;
    if (g == 0) begin
      e.busy_len = 67;
      e.cs_len   = 65;
      exp_q0.push_back(e);
    end else begin
      e.busy_len = 37;
      e.cs_len   = 33;
      exp_q1.push_back(e);
    end
  endtask

  task automatic tick_dut(input int g);
    @(posedge clk);
    #1;
    if (g == 0) tick0 = 1'b1;
    else        tick1 = 1'b1;
    @(posedge clk);
    #1;
    tick0 = 1'b0;
    tick1 = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while (n < 500 && ((g == 0) ? busy0 : busy1)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout dut%0d actual=busy required=idle", g);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 clr_overrun = 1'b1;
    @(posedge clk);
    #1 clr_overrun = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] wrap_addr [5];
  logic [7:0] sweep_addr [5];

  initial begin
    wrap_addr  = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00};
    sweep_addr = '{8'h00, 8'h33, 8'h66, 8'h99, 8'h99};
    rst_n       = 1'b1;
    enable      = 1'b1;
    clr_overrun = 1'b0;
    tick0       = 1'b0;
    tick1       = 1'b0;
    step0       = 8'h01;
    step1       = 8'h33;
    #1 rst_n = 1'b0;
    #1;
    // Reset values
    check("rst_rom_addr", 32'(rom_addr0), 32'h0);
    check("rst_sclk",     32'(sclk0),     32'h0);
    check("rst_cs_n",     32'(cs_n0),     32'h1);
    check("rst_so",       32'(so0),       32'h0);
    check("rst_busy",     32'(busy0),     32'h0);
    check("rst_overrun",  32'(ovr0),      32'h0);
    check("rst_cs_n1",    32'(cs_n1),     32'h1);
    check("rst_busy1",    32'(busy1),     32'h0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of SHIFT aborts the frame at once
    step0 = 8'h05;
    tick_dut(0);
    repeat (30) @(negedge clk);
    check("mid_frame_cs_active", 32'(cs_n0), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs_n",     32'(cs_n0),     32'h1);
    check("abort_sclk",     32'(sclk0),     32'h0);
    check("abort_busy",     32'(busy0),     32'h0);
    check("abort_rom_addr", 32'(rom_addr0), 32'h0);
    repeat (5) begin
      @(negedge clk);
      check("abort_no_sclk", 32'(sclk0), 32'h0);
    end
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame: ROM[0]=A5 -> 0011_1010_0101_0000
    step0 = 8'h01;
    push_exp(0, 16'h3A50);
    tick_dut(0);
    wait_idle(0);
    check("single_rom_addr", 32'(rom_addr0), 32'h01);

    // Phase wrap with step 0x40
    do_reset();
    step0 = 8'h40;
    for (int i = 0; i < 5; i++) begin
      push_exp(0, {4'b0011, rom_fn(wrap_addr[i]), 4'b0000});
      tick_dut(0);
      repeat (1000) @(negedge clk);
    end
    check("wrap_rom_addr", 32'(rom_addr0), 32'h40);

    // Overrun: second tick 10 cycles after acceptance
    push_exp(0, {4'b0011, rom_fn(8'h40), 4'b0000});
    tick_dut(0);
    repeat (8) @(posedge clk);
    tick_dut(0);
    check("overrun_set",  32'(ovr0),  32'h1);
    check("overrun_busy", 32'(busy0), 32'h1);
    wait_idle(0);
    check("overrun_sticky", 32'(ovr0), 32'h1);
    pulse_clr();
    check("overrun_clear", 32'(ovr0), 32'h0);
    push_exp(0, {4'b0011, rom_fn(8'h80), 4'b0000});
    tick_dut(0);
    repeat (5) @(posedge clk);
    #1;
    tick0       = 1'b1;
    clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    tick0       = 1'b0;
    clr_overrun = 1'b0;
    check("overrun_set_wins", 32'(ovr0), 32'h1);
    wait_idle(0);
    pulse_clr();
    check("overrun_clear2", 32'(ovr0), 32'h0);

    // Enable dropped mid-frame: frame completes; later ticks ignored
    push_exp(0, {4'b0011, rom_fn(8'hC0), 4'b0000});
    tick_dut(0);
    repeat (4) @(posedge clk);
    #1 enable = 1'b0;
    wait_idle(0);
    for (int i = 0; i < 3; i++) begin
      tick_dut(0);
      repeat (20) @(negedge clk);
      check("gated_busy",    32'(busy0), 32'h0);
      check("gated_cs_n",    32'(cs_n0), 32'h1);
      check("gated_overrun", 32'(ovr0),  32'h0);
    end
    check("gated_rom_addr", 32'(rom_addr0), 32'h00);
    enable = 1'b1;

    // Parameter sweep instance: ROM_LATENCY=3, SCLK_DIV=1
    for (int i = 0; i < 5; i++) begin
      step1 = (i < 2) ? 8'h33 : ((i == 2) ? 8'h33 : 8'h00);
      push_exp(1, {4'b0011, rom_fn(sweep_addr[i]), 4'b0000});
      tick_dut(1);
      wait_idle(1);
    end
    check("sweep_rom_addr", 32'(rom_addr1), 32'h99);

    repeat (10) @(negedge clk);
    check("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
    check("exp_q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/sine_dac_sequencer.md
Name: sine_dac_sequencer

Overview:
- Sequences the sine-sample path: on each sample tick, reads the next sample from the sine ROM, builds a 16-bit DAC command frame and shifts it out MSB-first.
- The serial link has a chip-select and a divided serial clock.
- A phase accumulator steps the ROM address, so phase_step sets the output frequency.
- Sits between the tick counter and the sine ROM / external serial DAC, and replaces free-running serialisation with a controlled frame handshake.

Parameters:
- ADDR_WIDTH, 8, ROM address width; phase wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 8, ROM sample width; fixed at 8 for the 16-bit frame.
- ROM_LATENCY, 1, clk cycles from rom_addr to valid rom_data (1..4).
- SCLK_DIV, 2, clk cycles per sclk half-period (>=1).
- CMD, 4'b0011, command nibble placed in the frame MSBs.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  one-cycle sample request.
- enable  input  1  when low, new ticks are ignored; a frame in progress still completes.
- phase_step  input  ADDR_WIDTH  address increment per accepted tick; sampled at acceptance.
- rom_addr  output  ADDR_WIDTH  ROM read address (phase register).
- rom_data  input  DATA_WIDTH  ROM read data.
- sclk  output  1  serial clock; idles low.
- cs_n  output  1  DAC chip-select, active low.
- SO  output  1  serial data out.
- busy  output  1  high from tick acceptance until the frame ends.
- overrun  output  1  sticky flag: a tick arrived while busy.
- clr_overrun  input  1  synchronous clear of overrun; set wins if both occur in the same cycle.

Behaviour:
- Reset (asynchronous, rst_n low), all outputs:
  - state IDLE, rom_addr=0, sclk=0, cs_n=1, SO=0, busy=0, overrun=0.
  - Shift register, bit and divider counters cleared.
  - Reset mid-frame aborts immediately: cs_n high, sclk low, phase=0.
- FSM states: IDLE, FETCH, LOAD, SHIFT, END.
- IDLE:
  - rom_addr holds the current phase.
  - tick=1 and enable=1 -> FETCH; busy=1 next cycle.
  - Phase is updated to phase+phase_step at acceptance, but rom_addr stays latched on the pre-increment value until the frame ends.
- FETCH: waits ROM_LATENCY cycles, then -> LOAD.
- LOAD, one cycle:
  - shift register <= {CMD, rom_data, 4'b0000}.
  - cs_n <= 0; SO <= frame bit 15 -> SHIFT.
- SHIFT:
  - Divider counts SCLK_DIV cycles per half-period.
  - sclk rises, then falls; the DAC samples SO on the rising edge.
  - On each falling edge, shift left and present the next bit on SO.
  - After the 16th falling edge (bit counter 15->wrap), go to END without a further shift; SO=0.
- END, one cycle:
  - cs_n <= 1, busy <= 0, rom_addr <= phase (new address) -> IDLE.
- Frame length from acceptance to busy low = ROM_LATENCY + 1 + 32*SCLK_DIV + 1 cycles. With defaults that is 67 cycles.
- Tick handling:
  - A tick while busy=1 is dropped; overrun set next cycle.
  - A tick in the END cycle is also dropped (busy still high).
  - A tick in IDLE with enable=0 is dropped without setting overrun.
- enable falling mid-frame: the frame completes normally, no truncation.
- Phase arithmetic: unsigned ADDR_WIDTH-bit add; carry discarded (wrap 255+1 -> 0). phase_step=0 repeats the same sample.
- sclk is never high while cs_n=1. cs_n is low for exactly 32*SCLK_DIV+1 cycles per frame.

Test Plan:
- Reset mid-frame: assert rst_n=0 during SHIFT -> cs_n=1, sclk=0, busy=0, rom_addr=0 within the same cycle (asynchronous), with no further sclk edges.
- Single frame: phase_step=1, ROM[0]=8'hA5, one tick -> SO sequence on 16 sclk rising edges = 0011_1010_0101_0000; busy high for 67 cycles; rom_addr=1 afterwards.
- Phase wrap: phase_step=8'h40, issue 5 ticks spaced 1000 cycles apart -> frames read addresses 0x00, 0x40, 0x80, 0xC0, 0x00.
- Overrun: tick again 10 cycles after acceptance -> second tick ignored, overrun=1 and stays set; clr_overrun pulse -> overrun=0; simultaneous clr and new overrun -> overrun=1.
- Enable gating: enable=0 at acceptance +5 cycles -> current frame completes with 16 bits; subsequent ticks produce no cs_n activity and overrun stays 0.
- Parameter sweep: ROM_LATENCY=3, SCLK_DIV=1 -> frame length 37 cycles; sampled data matches rom_data at rom_addr from 3 cycles earlier.
